// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD sector arbiter: FSM states, requester count
// and a small one-hot helper used by the top level.
package sd_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Convert a requester index into its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        idx_to_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_arb_rr.sv
// Two-way round-robin picker. When both requesters are pending it favours
// the one that was not served last; otherwise it picks whichever is pending.
module sd_arb_rr
    import sd_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending,
    input  logic               last_served,
    output logic               pick_valid,
    output logic               pick_idx
);

    logic pick_idx_s;

    // Choose the next owner from the pending set.
    always_comb begin
        pick_idx_s = 1'b0;
        if (pending[0] && pending[1]) begin
            pick_idx_s = ~last_served;
        end else if (pending[1]) begin
            pick_idx_s = 1'b1;
        end else begin
            pick_idx_s = 1'b0;
        end
    end

    assign pick_valid = |pending;
    assign pick_idx   = pick_idx_s;

endmodule

// File: rtl/sd_sector_arbiter.sv
// Arbitrates two sector requesters onto a single mist_io SD port.
// Optional ack watchdog: define SD_ARB_TIMEOUT_EN to enable a saturating
// 24-bit counter that aborts ISSUE/XFER after TIMEOUT_CYCLES and pulses rq_err.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd13500000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [1:0]  rq_rd,
    input  logic [1:0]  rq_wr,
    input  logic [31:0] rq_lba0,
    input  logic [31:0] rq_lba1,
    output logic [1:0]  rq_done,
    output logic [1:0]  rq_err,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_lba,
    input  logic        sd_ack,
    input  logic        sd_buff_wr_in,
    output logic        sd_buff_wr0,
    output logic        sd_buff_wr1,
    input  logic [7:0]  sd_buff_din0,
    input  logic [7:0]  sd_buff_din1,
    output logic [7:0]  sd_buff_din,
    output logic [1:0]  grant
);

    arb_state_t  state_r, state_nx_s;
    logic [1:0]  grant_r, grant_nx_s;
    logic        sd_rd_r, sd_rd_nx_s;
    logic        sd_wr_r, sd_wr_nx_s;
    logic [31:0] lba_r, lba_nx_s;
    logic [1:0]  done_r, done_nx_s;
    logic [1:0]  err_r, err_nx_s;
    logic        last_r, last_nx_s;
    logic        armed_r, armed_nx_s;
    logic        pick_valid_s;
    logic        pick_idx_s;
    logic        timeout_hit_s;

    sd_arb_rr u_rr (
        .pending     (rq_rd | rq_wr),
        .last_served (last_r),
        .pick_valid  (pick_valid_s),
        .pick_idx    (pick_idx_s)
    );

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_r, cnt_nx_s;

    // Watchdog counter: restarts on every state change, saturates at all-ones.
    always_comb begin
        if (state_nx_s != state_r) begin
            cnt_nx_s = 24'd0;
        end else if (((state_r == ISSUE) || (state_r == XFER)) && (cnt_r != 24'hFF_FFFF)) begin
            cnt_nx_s = cnt_r + 24'd1;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    assign timeout_hit_s = (cnt_r >= (TIMEOUT_CYCLES - 24'd1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_r;
        sd_rd_nx_s = sd_rd_r;
        sd_wr_nx_s = sd_wr_r;
        lba_nx_s   = lba_r;
        done_nx_s  = 2'b00;
        err_nx_s   = 2'b00;
        last_nx_s  = last_r;
        armed_nx_s = armed_r;
        case (state_r)
            IDLE: begin
                // An ack left high from earlier traffic must not count.
                armed_nx_s = 1'b0;
                if (pick_valid_s) begin
                    state_nx_s = ISSUE;
                    grant_nx_s = idx_to_onehot(pick_idx_s);
                    lba_nx_s   = pick_idx_s ? rq_lba1 : rq_lba0;
                    // Read wins when a requester raises both levels.
                    sd_rd_nx_s = rq_rd[pick_idx_s];
                    sd_wr_nx_s = ~rq_rd[pick_idx_s];
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (timeout_hit_s) begin
                    state_nx_s = IDLE;
                    sd_rd_nx_s = 1'b0;
                    sd_wr_nx_s = 1'b0;
                    grant_nx_s = 2'b00;
                    err_nx_s   = grant_r;
                    last_nx_s  = grant_r[1];
                end else if (sd_ack && armed_r) begin
                    state_nx_s = XFER;
                    sd_rd_nx_s = 1'b0;
                    sd_wr_nx_s = 1'b0;
                end else if (!sd_ack) begin
                    armed_nx_s = 1'b1;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            XFER: begin
                if (timeout_hit_s) begin
                    state_nx_s = IDLE;
                    grant_nx_s = 2'b00;
                    err_nx_s   = grant_r;
                    last_nx_s  = grant_r[1];
                end else if (!sd_ack) begin
                    state_nx_s = DONE;
                    done_nx_s  = grant_r;
                end else begin
                    state_nx_s = XFER;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
                grant_nx_s = 2'b00;
                last_nx_s  = grant_r[1];
            end
            default: begin
                state_nx_s = IDLE;
                grant_nx_s = 2'b00;
                sd_rd_nx_s = 1'b0;
                sd_wr_nx_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset leaves requester 1 as last served.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            grant_r <= 2'b00;
            sd_rd_r <= 1'b0;
            sd_wr_r <= 1'b0;
            lba_r   <= 32'd0;
            done_r  <= 2'b00;
            err_r   <= 2'b00;
            last_r  <= 1'b1;
            armed_r <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_r   <= 24'd0;
`endif
        end else begin
            state_r <= state_nx_s;
            grant_r <= grant_nx_s;
            sd_rd_r <= sd_rd_nx_s;
            sd_wr_r <= sd_wr_nx_s;
            lba_r   <= lba_nx_s;
            done_r  <= done_nx_s;
            err_r   <= err_nx_s;
            last_r  <= last_nx_s;
            armed_r <= armed_nx_s;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_r   <= cnt_nx_s;
`endif
        end
    end

    // Buffer steering stays combinational so strobe and data keep mist_io timing;
    // only the current owner ever sees the byte strobe.
    always_comb begin
        sd_buff_wr0 = sd_buff_wr_in & grant_r[0];
        sd_buff_wr1 = sd_buff_wr_in & grant_r[1];
        case (grant_r)
            2'b01:   sd_buff_din = sd_buff_din0;
            2'b10:   sd_buff_din = sd_buff_din1;
            default: sd_buff_din = 8'h00;
        endcase
    end

    assign grant   = grant_r;
    assign sd_rd   = sd_rd_r;
    assign sd_wr   = sd_wr_r;
    assign sd_lba  = lba_r;
    assign rq_done = done_r;
    assign rq_err  = err_r;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Self-checking bench for sd_sector_arbiter. Expected transfers are queued as
// requests are raised and popped when the DUT issues to the mist_io model.
module tb_sd_sector_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rq_rd = 2'b00, rq_wr = 2'b00;
    logic [31:0] rq_lba0 = 32'd0, rq_lba1 = 32'd0;
    logic [1:0]  rq_done, rq_err, grant;
    logic        sd_rd, sd_wr, sd_ack = 1'b0, sd_buff_wr_in = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_buff_wr0, sd_buff_wr1;
    logic [7:0]  sd_buff_din0 = 8'hA5, sd_buff_din1 = 8'h3C, sd_buff_din;

    typedef struct packed {
        logic [1:0]  grant;
        logic        wr;
        logic [31:0] lba;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    sd_sector_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .rq_rd         (rq_rd),
        .rq_wr         (rq_wr),
        .rq_lba0       (rq_lba0),
        .rq_lba1       (rq_lba1),
        .rq_done       (rq_done),
        .rq_err        (rq_err),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_lba        (sd_lba),
        .sd_ack        (sd_ack),
        .sd_buff_wr_in (sd_buff_wr_in),
        .sd_buff_wr0   (sd_buff_wr0),
        .sd_buff_wr1   (sd_buff_wr1),
        .sd_buff_din0  (sd_buff_din0),
        .sd_buff_din1  (sd_buff_din1),
        .sd_buff_din   (sd_buff_din),
        .grant         (grant)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] g, input logic w, input logic [31:0] l);
        exp_t e;
        e.grant = g;
        e.wr    = w;
        e.lba   = l;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        rq_rd = 2'b00;
        rq_wr = 2'b00;
        sd_ack = 1'b0;
        sd_buff_wr_in = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    // mist_io model: wait for the issue, compare against the scoreboard,
    // acknowledge, optionally stream strobes, then check the completion.
    task automatic serve(input int ack_delay, input int ack_len, input int strobes,
                         input bit pre_high, input logic [1:0] drop_mask, input bit scramble);
        exp_t e;
        int   cyc;
        int   n0;
        int   n1;
        int   len;
        int   dropped;
        cyc = 0;
        @(negedge clk_sys);
        while (!(sd_rd || sd_wr) && cyc < 50) begin
            @(negedge clk_sys);
            cyc++;
        end
        check_eq("issue_seen", 32'(cyc < 50), 32'd1);
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_eq("grant_issue", 32'(grant), 32'(e.grant));
        check_eq("sd_wr_dir", 32'(sd_wr), 32'(e.wr));
        check_eq("sd_rd_dir", 32'(sd_rd), 32'(!e.wr));
        check_eq("sd_lba", sd_lba, e.lba);
        if (pre_high) begin
            dropped = 0;
            repeat (5) begin
                @(negedge clk_sys);
                if (!(sd_rd || sd_wr)) dropped++;
            end
            check_eq("stale_ack_ignored", 32'(dropped), 32'd0);
            sd_ack = 1'b0;
            repeat (2) @(negedge clk_sys);
        end
        repeat (ack_delay) @(negedge clk_sys);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        check_eq("req_drop_on_ack", 32'({sd_rd, sd_wr}), 32'd0);
        rq_rd = rq_rd & ~drop_mask;
        rq_wr = rq_wr & ~drop_mask;
        if (scramble) begin
            rq_lba0 = ~rq_lba0;
            rq_lba1 = ~rq_lba1;
        end
        n0 = 0;
        n1 = 0;
        len = (ack_len > 2 * strobes) ? ack_len : 2 * strobes;
        for (int k = 0; k < len; k++) begin
            sd_buff_wr_in = (k < 2 * strobes) && (k % 2 == 0);
            #1;
            n0 += int'(sd_buff_wr0);
            n1 += int'(sd_buff_wr1);
            if (k == 0) check_eq("buff_din", 32'(sd_buff_din), 32'(e.grant[1] ? sd_buff_din1 : sd_buff_din0));
            @(negedge clk_sys);
        end
        sd_buff_wr_in = 1'b0;
        check_eq("strobes_req0", 32'(n0), e.grant[0] ? 32'(strobes) : 32'd0);
        check_eq("strobes_req1", 32'(n1), e.grant[1] ? 32'(strobes) : 32'd0);
        check_eq("lba_stable", sd_lba, e.lba);
        sd_ack = 1'b0;
        @(negedge clk_sys);
        check_eq("done_pulse", 32'(rq_done), 32'(e.grant));
        check_eq("grant_in_done", 32'(grant), 32'(e.grant));
        @(negedge clk_sys);
        check_eq("done_single", 32'(rq_done), 32'd0);
        check_eq("grant_idle", 32'(grant), 32'd0);
    endtask

    initial begin
        int run;
        int err_p;
        int done_p;
        int cyc;
        logic [1:0] err_val;
        bit seen_low;

        // Reset state
        #2;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_sd_req", 32'({sd_rd, sd_wr}), 32'd0);
        check_eq("rst_lba", sd_lba, 32'd0);
        check_eq("rst_done", 32'(rq_done), 32'd0);
        check_eq("rst_err", 32'(rq_err), 32'd0);
        apply_reset();

        // Single read, requester drops its level mid-transfer, lba scrambled
        rq_lba0 = 32'h0000_0100;
        rq_rd   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0100);
        serve(3, 520, 0, 1'b0, 2'b01, 1'b1);

        // Simultaneous read(0)/write(1) from reset: 0 first, then 1
        apply_reset();
        rq_lba0 = 32'h0000_1000;
        rq_lba1 = 32'h0000_2000;
        rq_rd   = 2'b01;
        rq_wr   = 2'b10;
        push_exp(2'b01, 1'b0, 32'h0000_1000);
        push_exp(2'b10, 1'b1, 32'h0000_2000);
        serve(3, 8, 0, 1'b0, 2'b01, 1'b0);
        serve(2, 8, 0, 1'b0, 2'b10, 1'b0);

        // Both held continuously: alternate 0,1,0,1 (rd wins over wr for requester 1)
        rq_lba0 = 32'h0000_00AA;
        rq_lba1 = 32'h0000_00BB;
        rq_rd   = 2'b11;
        rq_wr   = 2'b10;
        push_exp(2'b01, 1'b0, 32'h0000_00AA);
        push_exp(2'b10, 1'b0, 32'h0000_00BB);
        push_exp(2'b01, 1'b0, 32'h0000_00AA);
        push_exp(2'b10, 1'b0, 32'h0000_00BB);
        serve(1, 4, 0, 1'b0, 2'b00, 1'b0);
        serve(1, 4, 0, 1'b0, 2'b00, 1'b0);
        serve(1, 4, 0, 1'b0, 2'b00, 1'b0);
        serve(1, 4, 0, 1'b0, 2'b11, 1'b0);

        // 512 byte strobes during a requester-1 write
        rq_lba1 = 32'hDEAD_0001;
        rq_wr   = 2'b10;
        push_exp(2'b10, 1'b1, 32'hDEAD_0001);
        serve(3, 0, 512, 1'b0, 2'b10, 1'b0);

        // Ack already high when the request arrives
        sd_ack  = 1'b1;
        rq_lba0 = 32'h0000_0555;
        rq_rd   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0555);
        serve(1, 4, 3, 1'b1, 2'b01, 1'b0);

        // Ack never arrives for 150 cycles
        rq_lba0 = 32'h0000_0777;
        rq_rd   = 2'b01;
        run = 0;
        err_p = 0;
        done_p = 0;
        err_val = 2'b00;
        seen_low = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk_sys);
            if (sd_rd && !seen_low) run++;
            else seen_low = 1'b1;
            if (rq_err != 2'b00) begin
                err_p++;
                err_val = rq_err;
                rq_rd = 2'b00;
            end
            if (rq_done != 2'b00) done_p++;
        end
`ifdef SD_ARB_TIMEOUT_EN
        check_eq("timeout_rd_cycles", 32'(run), 32'd100);
        check_eq("timeout_err_pulses", 32'(err_p), 32'd1);
        check_eq("timeout_err_owner", 32'(err_val), 32'd1);
        check_eq("timeout_no_done", 32'(done_p), 32'd0);
`else
        check_eq("noack_rd_held", 32'(run), 32'd150);
        check_eq("noack_no_err", 32'(err_p), 32'd0);
        check_eq("noack_no_done", 32'(done_p), 32'd0);
        push_exp(2'b01, 1'b0, 32'h0000_0777);
        serve(2, 4, 0, 1'b0, 2'b01, 1'b0);
`endif

        // Reset in the middle of a transfer
        @(negedge clk_sys);
        rq_lba1 = 32'h0000_0999;
        rq_rd   = 2'b10;
        cyc = 0;
        @(negedge clk_sys);
        while (!sd_rd && cyc < 50) begin
            @(negedge clk_sys);
            cyc++;
        end
        check_eq("rst_test_issue", 32'(cyc < 50), 32'd1);
        check_eq("rst_test_grant", 32'(grant), 32'd2);
        sd_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        sd_buff_wr_in = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_grant", 32'(grant), 32'd0);
        check_eq("async_sd_req", 32'({sd_rd, sd_wr}), 32'd0);
        check_eq("async_lba", sd_lba, 32'd0);
        check_eq("async_done_err", 32'({rq_done, rq_err}), 32'd0);
        check_eq("async_buff_wr", 32'({sd_buff_wr0, sd_buff_wr1}), 32'd0);
        rq_rd = 2'b00;
        sd_ack = 1'b0;
        sd_buff_wr_in = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        done_p = 0;
        repeat (4) begin
            @(negedge clk_sys);
            if ((rq_done | rq_err) != 2'b00) done_p++;
        end
        check_eq("post_rst_no_pulse", 32'(done_p), 32'd0);
        rq_lba0 = 32'h0000_2468;
        rq_rd   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_2468);
        serve(3, 6, 2, 1'b0, 2'b01, 1'b0);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_sector_arbiter.md
SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd13500000, meaning the ack watchdog limit in clk_sys cycles.
REQ-002 SHALL have port clk_sys  input  1  system clock; the block has one clock, and it is this one.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports rq_rd[1:0] and rq_wr[1:0]  input  2 each  sector read/write request level from requester 0/1.
REQ-005 SHALL have ports rq_lba0 and rq_lba1  input  32 each  requested sector address.
REQ-006 SHALL have port rq_done  output  2  one-cycle completion pulse per requester.
REQ-007 SHALL have port rq_err  output  2  one-cycle timeout-abort pulse per requester.
REQ-008 SHALL have ports sd_rd and sd_wr  output  1 each  request to mist_io.
REQ-009 SHALL have port sd_lba  output  32  sector address to mist_io.
REQ-010 SHALL have port sd_ack  input  1  transfer-in-progress from mist_io.
REQ-011 SHALL have ports sd_buff_wr_in (input, 1) and sd_buff_wr0/1 (output, 1 each); byte strobe steered to the granted requester only.
REQ-012 SHALL have ports sd_buff_din0/1 (input, 8 each) and sd_buff_din (output, 8); write data muxed from the granted requester.
REQ-013 SHALL have port grant  output  2  one-hot current owner, 2'b00 when idle.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> XFER -> DONE -> IDLE.
REQ-015 IDLE: SHALL treat a requester as pending when rq_rd|rq_wr is set; it SHALL pick a pending requester by round-robin, favouring the one not served last (reset favours 0), and capture its lba and direction. If both rd and wr are set, rd SHALL win.
REQ-016 ISSUE: SHALL assert sd_rd or sd_wr from the cycle after the grant and hold it until the first cycle sd_ack==1, then go to XFER with sd_rd/sd_wr cleared.
REQ-017 XFER: SHALL steer the buffer signals to the owner; sd_buff_wr0/1 SHALL be 0 for the non-owner at all times. On sd_ack falling it SHALL go to DONE.
REQ-018 DONE: SHALL pulse rq_done[owner] for exactly one cycle, record the owner as last-served, clear grant, and return to IDLE; total arbitration overhead SHALL be 1 cycle in IDLE plus 1 cycle in DONE.
REQ-019 sd_lba SHALL remain stable from grant until DONE, regardless of changes on rq_lbaN.
REQ-020 A requester deasserting its request mid-transfer SHALL NOT abort it; completion is still pulsed.
REQ-021 A new request from the owner arriving in the DONE cycle SHALL be arbitrated normally; round-robin SHALL serve the other requester first if it is pending.
REQ-022 sd_ack already high in IDLE SHALL be ignored; ISSUE SHALL wait for sd_ack low before accepting a rising edge.

Reset
REQ-023 On reset_n low, SHALL asynchronously force state IDLE, sd_rd=0, sd_wr=0, sd_lba=0, grant=0, rq_done=0, rq_err=0, and last-served=1.
REQ-024 Reset mid-transfer SHALL drop the grant immediately and SHALL emit no done or err pulse.

Configuration
REQ-025 With SD_ARB_TIMEOUT_EN defined, a 24-bit counter SHALL run in ISSUE and XFER, clear on each state entry, and saturate; reaching TIMEOUT_CYCLES SHALL clear sd_rd/sd_wr, pulse rq_err[owner] instead of rq_done, and return to IDLE.
REQ-026 Without SD_ARB_TIMEOUT_EN, SHALL include no counter; rq_err SHALL be tied to 0 and the FSM SHALL wait indefinitely.

Structure
REQ-027 SHALL place the state enum (IDLE, ISSUE, XFER, DONE) and the requester count constant 2 in shared package sd_arb_pkg.
REQ-028 SHALL contain one sub-module, sd_arb_rr (a 2-way round-robin picker); buffer muxing SHALL stay inline.

Verification
REQ-029 Test: rq_rd[0], lba 0x100; sd_ack high 3 cycles after sd_rd, low 520 cycles later -> sd_lba=0x100, sd_rd drops on the ack cycle, single rq_done[0] pulse.
REQ-030 Test: rq_rd[0] and rq_wr[1] asserted together from reset -> requester 0 served first, then requester 1 with sd_wr; grant sequence 01, 00, 10.
REQ-031 Test: both requesters held continuously for 4 transfers -> grants alternate 0,1,0,1.
REQ-032 Test: during requester 1 XFER, pulse sd_buff_wr_in 512 times -> sd_buff_wr1 sees 512 pulses, sd_buff_wr0 sees 0; sd_buff_din equals sd_buff_din1.
REQ-033 Test: with TIMEOUT_EN and TIMEOUT_CYCLES=100, sd_ack never asserted -> sd_rd clears at cycle 100, rq_err[0] pulses, and no rq_done.
REQ-034 Test: reset_n low mid-XFER -> all outputs 0 asynchronously; after release a new request is served normally.
